// File: rtl/logic_gate_sched.sv
// rtl/logic_gate_sched.sv - round-robin scheduler sharing one registered bitwise logic unit
//
// Purpose: NREQ requesters present op/a/b with valid/ready. One winner is
// granted in IDLE (round-robin from last+1), its operands are evaluated in
// EXEC, and the result is held in RESP until the consumer accepts it.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot or zero)
//   req_op/req_a/req_b      packed per-requester opcode and operands
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_data/rsp_err owner id, result, illegal-opcode flag
//   busy                    high while not in IDLE
//   done_cnt                wrapping count of accepted responses

module logic_gate_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [15:0]           done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   win_id;
    logic             win_found;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result;
    logic             busy_r;

    // Search starts just after the last winner so a requester that keeps
    // req_valid high drops to lowest priority on the next round.
    always_comb begin
        win_found = 1'b0;
        win_id    = last;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req_valid[(int'(last) + k) % NREQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(last) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                // Gated by rst_n so no grant is visible while reset is held.
                if (rst_n && win_found) begin
                    req_ready = NREQ'(1) << win_id;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        case (op_r)
            3'd0:    result = ~a_r;
            3'd1:    result = a_r & b_r;
            3'd2:    result = a_r | b_r;
            3'd3:    result = ~(a_r & b_r);
            3'd4:    result = ~(a_r | b_r);
            3'd5:    result = a_r ^ b_r;
            3'd6:    result = ~(a_r ^ b_r);
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= IDW'(NREQ - 1);
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            busy_r   <= 1'b0;
            done_cnt <= '0;
        end else begin
            state  <= state_nxt;
            busy_r <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_r   <= req_op[3*win_id +: 3];
                        a_r    <= req_a[WIDTH*win_id +: WIDTH];
                        b_r    <= req_b[WIDTH*win_id +: WIDTH];
                        rsp_id <= win_id;
                        last   <= win_id;
                    end
                end
                EXEC: begin
                    rsp_data <= result;
                    rsp_err  <= (op_r == 3'd7);
                end
                RESP: begin
                    if (rsp_ready) done_cnt <= done_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = busy_r;

endmodule
